// File: rtl/seri_toplayici_if.sv
// Serial-in / word-out bus for the receive stage: serial bits and abort in,
// queued words out through a valid/ready handshake.
interface seri_toplayici_if #(
    parameter int BIT      = 4,
    parameter int DERINLIK = 4
);
    logic                          bit_girisi;
    logic                          gecerli_giris;
    logic                          iptal;
    logic                          cikis_hazir;
    logic [BIT-1:0]                kelime;
    logic                          kelime_gecerli;
    logic [$clog2(DERINLIK):0]     doluluk;
    logic                          tasma;

    modport master (
        output bit_girisi, gecerli_giris, iptal, cikis_hazir,
        input  kelime, kelime_gecerli, doluluk, tasma
    );

    modport slave (
        input  bit_girisi, gecerli_giris, iptal, cikis_hazir,
        output kelime, kelime_gecerli, doluluk, tasma
    );
endinterface

// File: rtl/seri_toplayici.sv
// Assembles LSB-first serial bits into BIT-wide words and queues them in a
// DERINLIK-deep FIFO with sticky overflow and partial-word abort.
module seri_toplayici #(
    parameter int BIT      = 4,
    parameter int DERINLIK = 4
) (
    input  logic             saat,
    input  logic             reset_n,
    seri_toplayici_if.slave  bus
);
    localparam int IW = $clog2(BIT);
    localparam int AW = $clog2(DERINLIK);
    localparam int CW = AW + 1;

    logic [IW-1:0]  idx_q, idx_d;
    logic [BIT-1:0] partial_q, partial_d;
    logic [BIT-1:0] mem_q [DERINLIK];
    logic [BIT-1:0] mem_d [DERINLIK];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tasma_q, tasma_d;

    logic [BIT-1:0] word;
    logic           accept, last, full, pop, push_ok;

    always_comb begin
        word          = partial_q;
        word[idx_q]   = bus.bit_girisi;
        accept        = bus.gecerli_giris && !bus.iptal;
        last          = accept && (idx_q == IW'(BIT-1));
        full          = (cnt_q == CW'(DERINLIK));
        pop           = (cnt_q != '0) && bus.cikis_hazir;
        // A full FIFO still takes a word when the head leaves on the same edge
        push_ok       = last && (!full || pop);

        idx_d     = idx_q;
        partial_d = partial_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        tasma_d   = tasma_q;

        if (bus.iptal) begin
            idx_d     = '0;
            partial_d = '0;
        end else if (accept) begin
            if (last) begin
                idx_d     = '0;
                partial_d = '0;
            end else begin
                idx_d     = idx_q + IW'(1);
                partial_d = word;
            end
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (last && full && !pop)
            tasma_d = 1'b1;
    end

    always_ff @(posedge saat or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            partial_q <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tasma_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            partial_q <= partial_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tasma_q   <= tasma_d;
        end
    end

    // Head is masked while empty so stale storage never shows on kelime
    assign bus.kelime         = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.kelime_gecerli = (cnt_q != '0);
    assign bus.doluluk        = cnt_q;
    assign bus.tasma          = tasma_q;
endmodule
